// File: rtl/ps2_event_fifo.sv
// PS/2 scan-byte decoder feeding a FIFO of {ext,brk,code} events for processor port reads.
// Optional auto-repeat suppression is built when PS2_TYPEMATIC_FILTER_EN is defined.
module ps2_event_fifo #(
  parameter int unsigned AW       = 3,
  parameter logic [7:0]  BRK_CODE = 8'hF0,
  parameter logic [7:0]  EXT_CODE = 8'hE0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_done_tick,
  input  logic [7:0]    rx_data,
  output logic          rx_en,
  input  logic          rd_ack,
  input  logic          clr_ovf,
  output logic          evt_valid,
  output logic [7:0]    evt_code,
  output logic          evt_ext,
  output logic          evt_brk,
  output logic [AW:0]   evt_count,
  output logic          overflow
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK} state_t;

  state_t      state_q, state_d;
  logic        ext_q, ext_d;
  logic        push_req, push_ext, push_brk, push_ok;

  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    push_req = 1'b0;
    push_ext = 1'b0;
    push_brk = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == EXT_CODE) begin
            state_d = S_EXT;
          end else if (rx_data == BRK_CODE) begin
            state_d = S_BRK;
            ext_d   = 1'b0;
          end else begin
            push_req = 1'b1;
          end
        end
        S_EXT: begin
          if (rx_data == BRK_CODE) begin
            state_d = S_BRK;
            ext_d   = 1'b1;
          end else if (rx_data != EXT_CODE) begin
            push_req = 1'b1;
            push_ext = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_BRK: begin
          // A prefix byte here is a protocol error: drop the partial sequence.
          if (rx_data != EXT_CODE && rx_data != BRK_CODE) begin
            push_req = 1'b1;
            push_ext = ext_q;
            push_brk = 1'b1;
          end
          state_d = S_IDLE;
          ext_d   = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          ext_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] held_q, held_d;
  logic       held_vld_q, held_vld_d;
  logic       held_hit;

  assign held_hit = held_vld_q && (held_q == {push_ext, rx_data});

  always_comb begin
    held_d     = held_q;
    held_vld_d = held_vld_q;
    push_ok    = push_req;
    if (push_req) begin
      if (!push_brk) begin
        if (held_hit) begin
          push_ok = 1'b0;
        end else begin
          held_d     = {push_ext, rx_data};
          held_vld_d = 1'b1;
        end
      end else if (held_hit) begin
        held_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q     <= '0;
      held_vld_q <= 1'b0;
    end else begin
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
    end
  end
`else
  assign push_ok = push_req;
`endif

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, wr_en, ovf_set;
  logic [9:0]    head;

  assign full    = (cnt_q == FULL_CNT);
  assign pop     = rd_ack && (cnt_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign wr_en   = push_ok && (!full || pop);
  assign ovf_set = push_ok && full && !pop;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en && !pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (!wr_en && pop) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {push_ext, push_brk, rx_data};
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign evt_valid = (cnt_q != '0);
  assign evt_code  = evt_valid ? head[7:0] : '0;
  assign evt_brk   = evt_valid ? head[8]   : 1'b0;
  assign evt_ext   = evt_valid ? head[9]   : 1'b0;
  assign evt_count = cnt_q;
  assign overflow  = ovf_q;
  assign rx_en     = !full;

endmodule
